// File: rtl/fa_call_scheduler.sv
// fa_call_scheduler: flight-attendant call scheduler.
//   Collects per-seat call requests into a pending vector, offers one call at a
//   time to the attendant in round-robin order, tracks the call in service, and
//   raises an escalation chime when a call has waited too long.
// Ports:
//   clk            - single clock, all state updates on the rising edge
//   reset          - synchronous active-high reset
//   call_button    - per-seat call request (level-sampled each edge)
//   cancel_button  - per-seat cancel (level-sampled each edge, beats call)
//   attendant_ack  - attendant accepts the offered call (OFFER only)
//   attendant_done - attendant finishes the call in service (SERVE only)
//   light_state    - per-seat light: pending OR in service
//   grant_valid    - a call is being offered
//   grant_seat     - seat offered or in service
//   busy           - a call is in service
//   pending_count  - number of pending seats (0..4)
//   chime          - escalation alert, high while the wait counter is saturated
module fa_call_scheduler #(
    parameter int NSEAT     = 4,
    parameter int ESC_LIMIT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NSEAT-1:0] call_button,
    input  logic [NSEAT-1:0] cancel_button,
    input  logic             attendant_ack,
    input  logic             attendant_done,
    output logic [NSEAT-1:0] light_state,
    output logic             grant_valid,
    output logic [1:0]       grant_seat,
    output logic             busy,
    output logic [2:0]       pending_count,
    output logic             chime
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        SERVE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [NSEAT-1:0] r_pending;
    logic [NSEAT-1:0] w_pend_next;
    logic [1:0]       r_grant_seat;
    logic [1:0]       r_rr_ptr;
    logic [3:0]       r_wait_cnt;

    logic [NSEAT-1:0] w_grant_oh;
    logic [NSEAT-1:0] w_serve_mask;
    logic [NSEAT-1:0] w_ack_clear;
    logic [NSEAT-1:0] w_avail;
    logic             w_found;
    logic [1:0]       w_pick;
    logic [1:0]       w_idx;
    logic             w_grant_cancel;

    // Population count of the pending vector.
    function automatic logic [2:0] popcount(input logic [NSEAT-1:0] v);
        logic [2:0] sum;
        sum = 3'd0;
        for (int i = 0; i < NSEAT; i++) begin
            sum = sum + {2'b00, v[i]};
        end
        return sum;
    endfunction

    assign w_grant_oh     = NSEAT'(1) << r_grant_seat;
    assign w_grant_cancel = |(cancel_button & w_grant_oh);
    // The seat in service is tracked by state + grant_seat, not by pending.
    assign w_serve_mask   = (r_state == SERVE) ? w_grant_oh : {NSEAT{1'b0}};
    // A seat being cancelled on this edge is not worth offering.
    assign w_avail        = r_pending & ~cancel_button;

    // Pending vector update: calls set, cancels clear (cancel wins), accepted
    // offer clears, calls on the in-service seat are ignored.
    always_comb begin
        w_ack_clear = {NSEAT{1'b0}};
        if (r_state == OFFER && attendant_ack) begin
            w_ack_clear = w_grant_oh;
        end else begin
            w_ack_clear = {NSEAT{1'b0}};
        end
        w_pend_next = (r_pending | (call_button & ~w_serve_mask))
                      & ~cancel_button & ~w_ack_clear;
    end

    // Round-robin pick: first available seat scanning from rr_ptr upwards.
    always_comb begin
        w_found = 1'b0;
        w_pick  = 2'd0;
        w_idx   = 2'd0;
        for (int k = 0; k < NSEAT; k++) begin
            w_idx = r_rr_ptr + 2'(k);
            if (!w_found && w_avail[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end else begin
                w_found = w_found;
            end
        end
    end

    // Next-state logic; a cancel of the granted seat beats a simultaneous ack.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_found) w_state_next = OFFER;
                else         w_state_next = IDLE;
            end
            OFFER: begin
                if (w_grant_cancel)     w_state_next = IDLE;
                else if (attendant_ack) w_state_next = SERVE;
                else                    w_state_next = OFFER;
            end
            SERVE: begin
                if (attendant_done || w_grant_cancel) w_state_next = IDLE;
                else                                  w_state_next = SERVE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // State, pending vector and grant bookkeeping registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_pending    <= {NSEAT{1'b0}};
            r_grant_seat <= 2'd0;
            r_rr_ptr     <= 2'd0;
        end else begin
            r_state   <= w_state_next;
            r_pending <= w_pend_next;
            if (r_state == IDLE && w_found) begin
                r_grant_seat <= w_pick;
            end
            // Only a finished/cancelled service moves the round-robin pointer.
            if (r_state == SERVE && w_state_next == IDLE) begin
                r_rr_ptr <= r_grant_seat + 2'd1;
            end
        end
    end

    // Wait counter: counts while calls wait outside SERVE, saturates at the limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait_cnt <= 4'd0;
        end else if (r_state == OFFER && w_state_next == SERVE) begin
            r_wait_cnt <= 4'd0;
        end else if (r_pending == {NSEAT{1'b0}}) begin
            r_wait_cnt <= 4'd0;
        end else if (r_state != SERVE && r_wait_cnt != 4'(ESC_LIMIT)) begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
        end
    end

    assign light_state   = r_pending | w_serve_mask;
    assign grant_valid   = (r_state == OFFER);
    assign busy          = (r_state == SERVE);
    assign grant_seat    = r_grant_seat;
    assign pending_count = popcount(r_pending);
    assign chime         = (r_wait_cnt == 4'(ESC_LIMIT));

endmodule

// File: tb/tb_fa_call_scheduler.sv
// Testbench for fa_call_scheduler: directed stimulus with hand-computed
// expectations pushed into a queue; a negedge monitor pops and compares.
module tb_fa_call_scheduler;

    logic       clk;
    logic       reset;
    logic [3:0] call_button;
    logic [3:0] cancel_button;
    logic       attendant_ack;
    logic       attendant_done;
    logic [3:0] light_state;
    logic       grant_valid;
    logic [1:0] grant_seat;
    logic       busy;
    logic [2:0] pending_count;
    logic       chime;

    fa_call_scheduler #(.NSEAT(4), .ESC_LIMIT(15)) dut (
        .clk            (clk),
        .reset          (reset),
        .call_button    (call_button),
        .cancel_button  (cancel_button),
        .attendant_ack  (attendant_ack),
        .attendant_done (attendant_done),
        .light_state    (light_state),
        .grant_valid    (grant_valid),
        .grant_seat     (grant_seat),
        .busy           (busy),
        .pending_count  (pending_count),
        .chime          (chime)
    );

    typedef struct {
        string      name;
        logic [3:0] light;
        logic       gv;
        logic [1:0] seat;
        logic       chk_seat;
        logic       busy;
        logic [2:0] pc;
        logic       chime;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compare the DUT outputs against the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            n_tests++;
            if (light_state !== e.light || grant_valid !== e.gv || busy !== e.busy ||
                pending_count !== e.pc || chime !== e.chime ||
                (e.chk_seat && grant_seat !== e.seat)) begin
                n_fail++;
                $display("FAIL %s: got light=%b gv=%b seat=%0d busy=%b pc=%0d chime=%b; want light=%b gv=%b seat=%0d busy=%b pc=%0d chime=%b",
                         e.name, light_state, grant_valid, grant_seat, busy, pending_count, chime,
                         e.light, e.gv, e.seat, e.busy, e.pc, e.chime);
            end
        end
    end

    // Drive one cycle of inputs, wait for the edge, then return inputs to idle.
    task automatic cyc(input logic [3:0] call, input logic [3:0] cancel,
                       input logic ack, input logic done, input logic rst);
        call_button    = call;
        cancel_button  = cancel;
        attendant_ack  = ack;
        attendant_done = done;
        reset          = rst;
        @(posedge clk);
        #1;
        call_button    = 4'b0000;
        cancel_button  = 4'b0000;
        attendant_ack  = 1'b0;
        attendant_done = 1'b0;
        reset          = 1'b0;
    endtask

    // Queue an expectation for the state just after the most recent edge.
    task automatic ex(input string name, input logic [3:0] light, input logic gv,
                      input logic [1:0] seat, input logic chk, input logic bsy,
                      input logic [2:0] pc, input logic chm);
        exp_t e;
        e.name = name; e.light = light; e.gv = gv; e.seat = seat;
        e.chk_seat = chk; e.busy = bsy; e.pc = pc; e.chime = chm;
        q.push_back(e);
    endtask

    initial begin
        call_button    = 4'b0000;
        cancel_button  = 4'b0000;
        attendant_ack  = 1'b0;
        attendant_done = 1'b0;
        reset          = 1'b1;
        @(negedge clk);

        // Reset state
        cyc(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1);
        cyc(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1);
        ex("reset", 4'b0000, 1'b0, 2'd0, 1'b1, 1'b0, 3'd0, 1'b0);
        n_tests++;
        if (light_state !== 4'b0000 || grant_valid !== 1'b0 || grant_seat !== 2'd0 ||
            busy !== 1'b0 || pending_count !== 3'd0 || chime !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_direct: light=%b gv=%b seat=%0d busy=%b pc=%0d chime=%b",
                     light_state, grant_valid, grant_seat, busy, pending_count, chime);
        end

        // Round-robin from rr_ptr=0: seats 0 and 3
        cyc(4'b1001, 4'b0000, 1'b0, 1'b0, 1'b0);
        ex("rr_pending", 4'b1001, 1'b0, 2'd0, 1'b0, 1'b0, 3'd2, 1'b0);
        cyc(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        ex("rr_offer0", 4'b1001, 1'b1, 2'd0, 1'b1, 1'b0, 3'd2, 1'b0);
        cyc(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
        ex("rr_serve0", 4'b1001, 1'b0, 2'd0, 1'b1, 1'b1, 3'd1, 1'b0);
        cyc(4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
        ex("rr_done0", 4'b1000, 1'b0, 2'd0, 1'b0, 1'b0, 3'd1, 1'b0);
        cyc(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        ex("rr_offer3", 4'b1000, 1'b1, 2'd3, 1'b1, 1'b0, 3'd1, 1'b0);
        cyc(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
        ex("rr_serve3", 4'b1000, 1'b0, 2'd3, 1'b1, 1'b1, 3'd0, 1'b0);
        cyc(4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
        ex("rr_done3", 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0);

        // Single call on seat 2 (rr_ptr ends at 3)
        cyc(4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0);
        ex("s2_light", 4'b0100, 1'b0, 2'd0, 1'b0, 1'b0, 3'd1, 1'b0);
        cyc(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        ex("s2_offer", 4'b0100, 1'b1, 2'd2, 1'b1, 1'b0, 3'd1, 1'b0);
        cyc(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
        ex("s2_serve", 4'b0100, 1'b0, 2'd2, 1'b1, 1'b1, 3'd0, 1'b0);
        cyc(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
        ex("s2_hold", 4'b0100, 1'b0, 2'd2, 1'b1, 1'b1, 3'd0, 1'b0);
        cyc(4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
        ex("s2_done", 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0);

        // rr_ptr=3 now: seats 0 and 3 -> seat 3 first; cancel offers
        cyc(4'b1001, 4'b0000, 1'b0, 1'b0, 1'b0);
        ex("p3_pending", 4'b1001, 1'b0, 2'd0, 1'b0, 1'b0, 3'd2, 1'b0);
        cyc(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        ex("p3_offer3", 4'b1001, 1'b1, 2'd3, 1'b1, 1'b0, 3'd2, 1'b0);
        cyc(4'b0000, 4'b1000, 1'b0, 1'b0, 1'b0);
        ex("p3_cancel3", 4'b0001, 1'b0, 2'd0, 1'b0, 1'b0, 3'd1, 1'b0);
        cyc(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        ex("p3_offer0", 4'b0001, 1'b1, 2'd0, 1'b1, 1'b0, 3'd1, 1'b0);
        cyc(4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0);
        ex("p3_cancel0", 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0);

        // Cancel races
        cyc(4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0);
        ex("race_pend1", 4'b0010, 1'b0, 2'd0, 1'b0, 1'b0, 3'd1, 1'b0);
        cyc(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        ex("race_offer1", 4'b0010, 1'b1, 2'd1, 1'b1, 1'b0, 3'd1, 1'b0);
        cyc(4'b0000, 4'b0010, 1'b1, 1'b0, 1'b0);
        ex("race_ack_cancel", 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0);
        cyc(4'b0100, 4'b0100, 1'b0, 1'b0, 1'b0);
        ex("race_call_cancel", 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0);
        cyc(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        ex("race_stay_idle", 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0);

        // Count: all four seats, then a call on the in-service seat
        cyc(4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0);
        ex("cnt_four", 4'b1111, 1'b0, 2'd0, 1'b0, 1'b0, 3'd4, 1'b0);
        cyc(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        ex("cnt_offer3", 4'b1111, 1'b1, 2'd3, 1'b1, 1'b0, 3'd4, 1'b0);
        cyc(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
        ex("cnt_serve3", 4'b1111, 1'b0, 2'd3, 1'b1, 1'b1, 3'd3, 1'b0);
        cyc(4'b1000, 4'b0000, 1'b0, 1'b0, 1'b0);
        ex("cnt_ignore3", 4'b1111, 1'b0, 2'd3, 1'b1, 1'b1, 3'd3, 1'b0);
        cyc(4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0);
        ex("cnt_cancel0", 4'b1110, 1'b0, 2'd3, 1'b1, 1'b1, 3'd2, 1'b0);

        // Reset mid-SERVE with seats 1 and 2 pending overrides all inputs
        cyc(4'b1111, 4'b0000, 1'b1, 1'b0, 1'b1);
        ex("rst_serve", 4'b0000, 1'b0, 2'd0, 1'b1, 1'b0, 3'd0, 1'b0);
        cyc(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        ex("rst_after", 4'b0000, 1'b0, 2'd0, 1'b1, 1'b0, 3'd0, 1'b0);

        // Escalation: seat 0 waits unacknowledged
        cyc(4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0);
        ex("esc_pend", 4'b0001, 1'b0, 2'd0, 1'b0, 1'b0, 3'd1, 1'b0);
        cyc(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        ex("esc_offer", 4'b0001, 1'b1, 2'd0, 1'b1, 1'b0, 3'd1, 1'b0);
        for (int i = 0; i < 12; i++) begin
            cyc(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        end
        cyc(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        ex("esc_cnt14", 4'b0001, 1'b1, 2'd0, 1'b1, 1'b0, 3'd1, 1'b0);
        cyc(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        ex("esc_chime", 4'b0001, 1'b1, 2'd0, 1'b1, 1'b0, 3'd1, 1'b1);
        n_tests++;
        if (chime !== 1'b1 || grant_valid !== 1'b1 || pending_count !== 3'd1) begin
            n_fail++;
            $display("FAIL esc_expired_direct: chime=%b gv=%b pc=%0d; want chime=1 gv=1 pc=1",
                     chime, grant_valid, pending_count);
        end
        cyc(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        ex("esc_held", 4'b0001, 1'b1, 2'd0, 1'b1, 1'b0, 3'd1, 1'b1);
        cyc(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
        ex("esc_ack", 4'b0001, 1'b0, 2'd0, 1'b1, 1'b1, 3'd0, 1'b0);
        cyc(4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
        ex("esc_done", 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 3'd0, 1'b0);

        @(posedge clk);
        @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
